raiz_bus_master: RTL

//  Bus initiator that drives one full square-root job on the memory-mapped raiz peripheral.
//  It is the requester side of the cs/addr/rd/wr register protocol.

---
 rtl/raiz_map_pkg.sv | 36 +++
 rtl/raiz_poll_timer.sv | 27 ++
 rtl/raiz_bus_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/raiz_map_pkg.sv
// Register map of the raiz peripheral and the bus-master state encoding.
// Shared by raiz_bus_master and raiz_poll_timer.
package raiz_map_pkg;

  localparam int RAIZ_ADDR_W = 5;

  localparam logic [RAIZ_ADDR_W-1:0] A_OPA  = 5'h04;
  localparam logic [RAIZ_ADDR_W-1:0] A_INIT = 5'h08;
  localparam logic [RAIZ_ADDR_W-1:0] A_RES  = 5'h0C;
  localparam logic [RAIZ_ADDR_W-1:0] A_DONE = 5'h10;

  localparam int DONE_BIT = 0;

  localparam logic [3:0] ENC_IDLE         = 4'd0;
  localparam logic [3:0] ENC_WR_CLR       = 4'd1;
  localparam logic [3:0] ENC_WR_OPA       = 4'd2;
  localparam logic [3:0] ENC_WR_INIT      = 4'd3;
  localparam logic [3:0] ENC_RD_DONE_REQ  = 4'd4;
  localparam logic [3:0] ENC_RD_DONE_WAIT = 4'd5;
  localparam logic [3:0] ENC_RD_RES_REQ   = 4'd6;
  localparam logic [3:0] ENC_RD_RES_WAIT  = 4'd7;
  localparam logic [3:0] ENC_WR_FIN       = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE         = ENC_IDLE,
    ST_WR_CLR       = ENC_WR_CLR,
    ST_WR_OPA       = ENC_WR_OPA,
    ST_WR_INIT      = ENC_WR_INIT,
    ST_RD_DONE_REQ  = ENC_RD_DONE_REQ,
    ST_RD_DONE_WAIT = ENC_RD_DONE_WAIT,
    ST_RD_RES_REQ   = ENC_RD_RES_REQ,
    ST_RD_RES_WAIT  = ENC_RD_RES_WAIT,
    ST_WR_FIN       = ENC_WR_FIN
  } raiz_mst_state_t;

endpackage

// File: rtl/raiz_poll_timer.sv
// Counts DONE polls that came back 0; o_last flags that the next such poll
// exhausts the TIMEOUT_POLLS budget.
module raiz_poll_timer #(
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_last
);

  localparam int CNT_W = $clog2(TIMEOUT_POLLS + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_last = (r_cnt == CNT_W'(TIMEOUT_POLLS - 1));

endmodule

// File: rtl/raiz_bus_master.sv
// Bus initiator running one square-root job on the raiz peripheral.
// Optional DONE-poll timeout is compiled in with RAIZ_MST_TIMEOUT_EN.
module raiz_bus_master
  import raiz_map_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 5,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] operand,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic              bus_cs,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  if (TIMEOUT_POLLS < 1) begin : g_bad_cfg
    $error("raiz_bus_master: TIMEOUT_POLLS must be at least 1");
  end

  raiz_mst_state_t   r_state;
  raiz_mst_state_t   w_state_nx;
  logic              r_busy;
  logic              r_done;
  logic              r_cs;
  logic              r_rd;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_opnd;

  logic              w_busy;
  logic              w_done;
  logic              w_cs;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_result;
  logic              w_accept;
  logic              w_done_seen;
  logic              w_timeout;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_done_seen = bus_rdata[DONE_BIT];

`ifdef RAIZ_MST_TIMEOUT_EN
  logic r_err;
  logic w_err;
  logic w_timer_clr;
  logic w_timer_inc;
  logic w_timer_last;

  // Counter restarts on the WR_INIT -> RD_DONE_REQ entry only, so the
  // re-polls of one job accumulate against the same budget.
  assign w_timer_clr = (r_state == ST_WR_INIT);
  assign w_timer_inc = (r_state == ST_RD_DONE_WAIT) && !w_done_seen;
  assign w_timeout   = w_timer_last;

  raiz_poll_timer #(
    .TIMEOUT_POLLS (TIMEOUT_POLLS)
  ) u_poll_timer (
    .i_clk  (CLK),
    .i_rst  (reset),
    .i_clr  (w_timer_clr),
    .i_inc  (w_timer_inc),
    .o_last (w_timer_last)
  );

  always_comb begin
    w_err = r_err;
    if (w_accept) begin
      w_err = 1'b0;
    end else if ((r_state == ST_RD_DONE_WAIT) && !w_done_seen && w_timeout) begin
      w_err = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    w_result   = r_result;
    case (r_state)
      ST_IDLE:         if (start) w_state_nx = ST_WR_CLR;
      ST_WR_CLR:       w_state_nx = ST_WR_OPA;
      ST_WR_OPA:       w_state_nx = ST_WR_INIT;
      ST_WR_INIT:      w_state_nx = ST_RD_DONE_REQ;
      ST_RD_DONE_REQ:  w_state_nx = ST_RD_DONE_WAIT;
      ST_RD_DONE_WAIT: begin
        if (w_done_seen) begin
          w_state_nx = ST_RD_RES_REQ;
        end else if (w_timeout) begin
          w_state_nx = ST_WR_FIN;
        end else begin
          w_state_nx = ST_RD_DONE_REQ;
        end
      end
      ST_RD_RES_REQ:   w_state_nx = ST_RD_RES_WAIT;
      ST_RD_RES_WAIT: begin
        w_state_nx = ST_WR_FIN;
        w_result   = bus_rdata;
      end
      ST_WR_FIN:       w_state_nx = ST_IDLE;
      default:         w_state_nx = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered
  // yet line up with the state they belong to.
  always_comb begin
    w_cs    = 1'b0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    case (w_state_nx)
      ST_WR_CLR, ST_WR_FIN: begin
        w_cs    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = ADDR_W'(A_INIT);
        w_wdata = '0;
      end
      ST_WR_OPA: begin
        w_cs    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = ADDR_W'(A_OPA);
        w_wdata = r_opnd;
      end
      ST_WR_INIT: begin
        w_cs    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = ADDR_W'(A_INIT);
        w_wdata = DATA_W'(1);
      end
      ST_RD_DONE_REQ: begin
        w_cs   = 1'b1;
        w_rd   = 1'b1;
        w_addr = ADDR_W'(A_DONE);
      end
      ST_RD_RES_REQ: begin
        w_cs   = 1'b1;
        w_rd   = 1'b1;
        w_addr = ADDR_W'(A_RES);
      end
      default: begin
        w_cs = 1'b0;
      end
    endcase
    w_busy = (w_state_nx != ST_IDLE);
    w_done = (r_state == ST_WR_FIN);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs     <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_cs     <= w_cs;
      r_rd     <= w_rd;
      r_wr     <= w_wr;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_result <= w_result;
    end
  end

  // Operand is plain data: only meaningful after an accepted start.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_opnd <= operand;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign bus_cs    = r_cs;
  assign bus_rd    = r_rd;
  assign bus_wr    = r_wr;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

endmodule
